// File: rtl/data_memory.sv
// Word-organised data memory: synchronous full-word stores, combinational loads,
// asynchronous active-high reset that clears the whole array.
module data_memory #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MemAddr,
  input  logic [31:0] MemWriteData,
  input  logic        MemWriteEnable,
  input  logic        MemReadEnable,
  output logic [31:0] MemReadData
);

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          unused_addr_lo;

  // Byte offset within a word is ignored: misaligned accesses round down.
  assign unused_addr_lo = ^MemAddr[1:0];

  always_comb begin
    word_idx = MemAddr[AW+1:2];
    in_range = (MemAddr[31:AW+2] == '0);
  end

  // Next-state image of the array; an X/Z enable fails the if and writes nothing.
  always_comb begin
    mem_d = mem_q;
    if (MemWriteEnable && in_range) begin
      mem_d[word_idx] = MemWriteData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    MemReadData = '0;
    if (MemReadEnable && in_range && !reset) begin
      MemReadData = mem_q[word_idx];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus pushes expected load results,
// a negedge monitor pops and compares against MemReadData.
`timescale 1ns/100ps
module tb_data_memory;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned LIMIT = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] MemAddr;
  logic [31:0] MemWriteData;
  logic        MemWriteEnable;
  logic        MemReadEnable;
  logic [31:0] MemReadData;

  data_memory #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .MemAddr        (MemAddr),
    .MemWriteData   (MemWriteData),
    .MemWriteEnable (MemWriteEnable),
    .MemReadEnable  (MemReadEnable),
    .MemReadData    (MemReadData)
  );

  always #1 clk = ~clk;

  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];
  string       name_q [$];
  logic [31:0] addr_q [$];
  bit          chk_req = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // Reference: a load returns the stored word when enabled, not in reset and below LIMIT.
  function automatic logic [31:0] ref_read(input logic [31:0] a, input bit re);
    if (re && !reset && a < LIMIT) return model[int'(a / 4)];
    return 32'h0;
  endfunction

  task automatic set_rst(input bit v);
    reset = v;
    if (v) begin
      for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;
    end
  endtask

  // Called at posedge+0.2: drive one cycle, optionally queue a check for this cycle's
  // negedge, then retire any store at the following edge in the model.
  task automatic step(input bit we, input bit re, input logic [31:0] a,
                      input logic [31:0] d, input bit chk, input string nm);
    MemWriteEnable = we;
    MemReadEnable  = re;
    MemAddr        = a;
    MemWriteData   = d;
    if (chk) begin
      exp_q.push_back(ref_read(a, re));
      name_q.push_back(nm);
      addr_q.push_back(a);
    end
    chk_req = chk;
    @(posedge clk);
    if (we && !reset && a < LIMIT) model[int'(a / 4)] = d;
    #0.2;
  endtask

  always @(negedge clk) begin
    if (chk_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow got=%h", MemReadData);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string       n = name_q.pop_front();
        automatic logic [31:0] a = addr_q.pop_front();
        if (MemReadData !== e) begin
          errors++;
          $display("FAIL %s addr=%h got=%h exp=%h", n, a, MemReadData, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    bit          we;
    bit          re;
    MemAddr = '0; MemWriteData = '0; MemWriteEnable = 1'b0; MemReadEnable = 1'b0;
    set_rst(1'b1);
    @(posedge clk); #0.2;
    step(1'b0, 1'b1, 32'h10, 32'h0, 1'b1, "reset_init");
    set_rst(1'b0);

    // Preload, then reset with clock running.
    step(1'b1, 1'b0, 32'h00, 32'hA5A5_0001, 1'b0, "");
    step(1'b1, 1'b0, 32'h10, 32'h0000_1234, 1'b0, "");
    step(1'b1, 1'b0, 32'hFC, 32'h0000_CAFE, 1'b0, "");
    step(1'b0, 1'b1, 32'hFC, 32'h0, 1'b1, "preload_fc");
    set_rst(1'b1);
    step(1'b0, 1'b1, 32'h00, 32'h0, 1'b1, "in_rst_00");
    step(1'b0, 1'b1, 32'h10, 32'h0, 1'b1, "in_rst_10");
    step(1'b0, 1'b1, 32'hFC, 32'h0, 1'b1, "in_rst_fc");
    set_rst(1'b0);
    step(1'b0, 1'b1, 32'h00, 32'h0, 1'b1, "post_rst_00");
    step(1'b0, 1'b1, 32'h10, 32'h0, 1'b1, "post_rst_10");
    step(1'b0, 1'b1, 32'hFC, 32'h0, 1'b1, "post_rst_fc");

    // Basic store/load.
    step(1'b1, 1'b0, 32'h10, 32'h4, 1'b0, "");
    step(1'b0, 1'b1, 32'h10, 32'h0, 1'b1, "basic_rd");
    step(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, "basic_re0");

    // Word alignment.
    step(1'b1, 1'b0, 32'h20, 32'hDEAD_BEEF, 1'b0, "");
    step(1'b0, 1'b1, 32'h21, 32'h0, 1'b1, "align_21");
    step(1'b0, 1'b1, 32'h22, 32'h0, 1'b1, "align_22");
    step(1'b0, 1'b1, 32'h23, 32'h0, 1'b1, "align_23");
    step(1'b0, 1'b1, 32'h24, 32'h0, 1'b1, "align_24");

    // Read during write.
    step(1'b1, 1'b0, 32'h08, 32'h11, 1'b0, "");
    step(1'b1, 1'b1, 32'h08, 32'h55, 1'b1, "rdw_before");
    step(1'b0, 1'b1, 32'h08, 32'h0, 1'b1, "rdw_after");

    // Out of range must neither alias onto word 0 nor read back.
    step(1'b1, 1'b0, 32'h00, 32'h0000_600D, 1'b0, "");
    step(1'b1, 1'b1, 32'h100, 32'hFFFF, 1'b1, "oor_rd");
    step(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF, 1'b0, "");
    step(1'b0, 1'b1, 32'h00, 32'h0, 1'b1, "oor_word0");

    // Reset wins over a coincident write.
    set_rst(1'b1);
    step(1'b1, 1'b0, 32'h04, 32'h7, 1'b0, "");
    set_rst(1'b0);
    step(1'b0, 1'b1, 32'h04, 32'h0, 1'b1, "rstwr_4");
    step(1'b1, 1'b0, 32'h04, 32'h9, 1'b0, "");
    step(1'b0, 1'b1, 32'h04, 32'h0, 1'b1, "rstwr_next");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) set_rst(1'b1);
      else if (reset) set_rst(1'b0);
      case ($urandom_range(0, 3))
        0:       a = $urandom_range(0, LIMIT - 1);
        3:       a = $urandom_range(LIMIT, 32'hFFFF_FFFF);
        default: a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      endcase
      we = $urandom_range(0, 2) == 0;
      re = $urandom_range(0, 3) != 0;
      step(we, re, a, $urandom, 1'b1, "random");
    end

    set_rst(1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, "");
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, "");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
